// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared definitions for the core's instruction-decode register file.
//   rf_state_t : register-file life cycle, clearing sweep (RF_INIT) followed by
//                normal operation (RF_RUN).
//   CORE_XLEN  : default register data width.
//   CORE_NREG  : default number of architectural registers.
// ---------------------------------------------------------------------------
package core_pkg;

   localparam int CORE_XLEN = 32;
   localparam int CORE_NREG = 32;

   typedef enum logic {
      RF_INIT,
      RF_RUN
   } rf_state_t;

endpackage

// File: rtl/core_id_reg_file_sb.sv
// ---------------------------------------------------------------------------
// core_id_reg_file_sb
// Pending-register scoreboard. One bit per architectural register marks a
// destination that has been reserved by an issued instruction but not yet
// written back.
//   clk, rst   : clock, synchronous active-high reset (clears all bits)
//   set_en     : reserve set_addr (already qualified by the caller)
//   set_addr   : register to mark pending
//   clr_en     : per write port, clear the bit at the port's address
//   clr_addr   : packed write-port addresses, port j at [j*AW +: AW]
//   look_addr  : packed read-port addresses, port i at [i*AW +: AW]
//   look_busy  : per read port, pending value as it will be after this edge
// A reservation wins over a clear of the same register in the same cycle,
// because the destination belongs to the newly issued instruction.
// ---------------------------------------------------------------------------
module core_id_reg_file_sb
#(
   parameter  int NREG = 32,
   parameter  int NRD  = 2,
   parameter  int NWR  = 2,
   localparam int AW   = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              set_en,
   input  logic [AW-1:0]     set_addr,
   input  logic [NWR-1:0]    clr_en,
   input  logic [NWR*AW-1:0] clr_addr,
   input  logic [NRD*AW-1:0] look_addr,
   output logic [NRD-1:0]    look_busy
);

   logic [NREG-1:0] pending_q;
   logic [NREG-1:0] pending_d;

   // Guards indexing when NREG is not a power of two.
   function automatic logic in_range(input logic [AW-1:0] a);
      return {1'b0, a} < (AW+1)'(NREG);
   endfunction

   always_comb begin
      pending_d = pending_q;
      for (int j = 0; j < NWR; j++) begin
         if (clr_en[j] && in_range(clr_addr[j*AW +: AW])) begin
            pending_d[clr_addr[j*AW +: AW]] = 1'b0;
         end
      end
      // Applied after the clears so it takes priority.
      if (set_en && in_range(set_addr)) begin
         pending_d[set_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   // Lookup sees the post-edge value so a read captures same-cycle set/clear.
   always_comb begin
      look_busy = '0;
      for (int i = 0; i < NRD; i++) begin
         if (in_range(look_addr[i*AW +: AW])) begin
            look_busy[i] = pending_d[look_addr[i*AW +: AW]];
         end
      end
   end

endmodule

// File: rtl/core_id_reg_file_mp.sv
// ---------------------------------------------------------------------------
// core_id_reg_file_mp
// Multi-ported register file for the decode stage with write bypass, a
// pending-register scoreboard and a self-clearing start-up sweep.
//   clk, rst  : clock, synchronous active-high reset
//   rd_en     : per read port enable; a disabled port holds its outputs
//   rd_addr   : packed read addresses, port i at [i*AW +: AW]
//   rd_data   : packed registered read data, port i at [i*XLEN +: XLEN]
//   rd_busy   : registered pending flag of each port's captured address
//   wr_en     : per write port enable
//   wr_addr   : packed write addresses
//   wr_data   : packed write data
//   rsv_en    : reserve (mark pending) rsv_addr
//   rsv_addr  : destination register of the issued instruction
//   init_done : high once the clearing sweep has finished
// Register 0 is hard-wired to zero; addresses >= NREG read as zero and are
// never written or reserved. While the sweep runs, external writes and
// reservations are dropped and enabled reads return zero.
// ---------------------------------------------------------------------------
module core_id_reg_file_mp
   import core_pkg::*;
#(
   parameter  int XLEN = CORE_XLEN,
   parameter  int NREG = CORE_NREG,
   parameter  int NRD  = 2,
   parameter  int NWR  = 2,
   localparam int AW   = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD-1:0]      rd_en,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic                rsv_en,
   input  logic [AW-1:0]       rsv_addr,
   output logic                init_done
);

   rf_state_t       state_q, state_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic            init_we;
   logic            run;

   logic [XLEN-1:0] regs [NREG];

   logic [NWR-1:0]  wr_ok;
   logic            rsv_ok;
   logic [XLEN-1:0] rd_d_nxt [NRD];
   logic [NRD-1:0]  rd_b_nxt;
   logic [NRD-1:0]  sb_busy;

   // Nonzero and inside the implemented register range.
   function automatic logic addr_ok(input logic [AW-1:0] a);
      return (a != '0) && ({1'b0, a} < (AW+1)'(NREG));
   endfunction

   // ------------------------------------------------------------------
   // Clearing sweep: one register per cycle, then RUN until reset.
   // ------------------------------------------------------------------
   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RF_INIT;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // NOTE: every output of a combinational block gets a default first so no
   // path leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      init_we = 1'b0;
      case (state_q)
         RF_INIT: begin
            init_we = 1'b1;
            if (idx_q == AW'(NREG - 1)) begin
               state_d = RF_RUN;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         RF_RUN:  state_d = RF_RUN;
         default: state_d = RF_INIT;
      endcase
   end

   assign run       = (state_q == RF_RUN);
   assign init_done = run;

   // ------------------------------------------------------------------
   // Write / reservation qualification
   // ------------------------------------------------------------------
   always_comb begin
      wr_ok = '0;
      for (int j = 0; j < NWR; j++) begin
         wr_ok[j] = run && wr_en[j] && addr_ok(wr_addr[j*AW +: AW]);
      end
   end

   assign rsv_ok = run && rsv_en && addr_ok(rsv_addr);

   // ------------------------------------------------------------------
   // Storage. Higher-index ports are applied later in the loop, so they
   // win when several ports hit the same register.
   // ------------------------------------------------------------------
   // NOTE: the register array has no reset; contents are zeroed by the
   // INIT sweep instead, which keeps the array mappable to plain storage.
   always_ff @(posedge clk) begin
      if (init_we) begin
         regs[idx_q] <= '0;
      end
      for (int j = 0; j < NWR; j++) begin
         if (wr_ok[j]) begin
            regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
         end
      end
   end

   // ------------------------------------------------------------------
   // Read path with same-cycle bypass (highest-index matching port wins)
   // ------------------------------------------------------------------
   always_comb begin
      for (int i = 0; i < NRD; i++) begin
         rd_d_nxt[i] = '0;
         rd_b_nxt[i] = 1'b0;
         if (run && addr_ok(rd_addr[i*AW +: AW])) begin
            rd_d_nxt[i] = regs[rd_addr[i*AW +: AW]];
            rd_b_nxt[i] = sb_busy[i];
            for (int j = 0; j < NWR; j++) begin
               if (wr_ok[j] && (wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])) begin
                  rd_d_nxt[i] = wr_data[j*XLEN +: XLEN];
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= '0;
         rd_busy <= '0;
      end else begin
         for (int i = 0; i < NRD; i++) begin
            if (rd_en[i]) begin
               rd_data[i*XLEN +: XLEN] <= rd_d_nxt[i];
               rd_busy[i]              <= rd_b_nxt[i];
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Scoreboard
   // ------------------------------------------------------------------
   core_id_reg_file_sb #(
      .NREG (NREG),
      .NRD  (NRD),
      .NWR  (NWR)
   ) u_sb (
      .clk       (clk),
      .rst       (rst),
      .set_en    (rsv_ok),
      .set_addr  (rsv_addr),
      .clr_en    (wr_ok),
      .clr_addr  (wr_addr),
      .look_addr (rd_addr),
      .look_busy (sb_busy)
   );

endmodule

// File: tb/tb_core_id_reg_file_mp.sv
// ---------------------------------------------------------------------------
// tb_core_id_reg_file_mp
// Directed scenarios plus randomized traffic for core_id_reg_file_mp. The
// reference model keeps an array of register values, a pending-bit array and
// a count of cycles since reset; the sweep is modelled simply as "after NREG
// cycles everything reads zero and the file is live".
// ---------------------------------------------------------------------------
module tb_core_id_reg_file_mp;
   import core_pkg::*;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int NRD  = 2;
   localparam int NWR  = 2;
   localparam int AW   = $clog2(NREG);

   logic                clk = 1'b0;
   logic                rst;
   logic [NRD-1:0]      rd_en;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic [NWR-1:0]      wr_en;
   logic [NWR*AW-1:0]   wr_addr;
   logic [NWR*XLEN-1:0] wr_data;
   logic                rsv_en;
   logic [AW-1:0]       rsv_addr;
   logic                init_done;

   core_id_reg_file_mp #(
      .XLEN (XLEN),
      .NREG (NREG),
      .NRD  (NRD),
      .NWR  (NWR)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_busy   (rd_busy),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rsv_en    (rsv_en),
      .rsv_addr  (rsv_addr),
      .init_done (init_done)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model state ----------------
   logic [XLEN-1:0] m_regs [NREG];
   bit              m_pend [NREG];
   int              m_cnt = 0;
   logic [XLEN-1:0] m_hd [NRD];
   bit              m_hb [NRD];

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      rst      = 1'b0;
      rd_en    = '0;
      rd_addr  = '0;
      wr_en    = '0;
      wr_addr  = '0;
      wr_data  = '0;
      rsv_en   = 1'b0;
      rsv_addr = '0;
   endtask

   task automatic set_rd(input int p, input bit en, input int a);
      rd_en[p]            = en;
      rd_addr[p*AW +: AW] = AW'(a);
   endtask

   task automatic set_wr(input int p, input bit en, input int a, input logic [XLEN-1:0] d);
      wr_en[p]                = en;
      wr_addr[p*AW +: AW]     = AW'(a);
      wr_data[p*XLEN +: XLEN] = d;
   endtask

   task automatic set_rsv(input bit en, input int a);
      rsv_en   = en;
      rsv_addr = AW'(a);
   endtask

   // Advance one clock: predict from the current inputs, then compare.
   task automatic step();
      bit run;
      int a;
      if (rst) begin
         m_cnt = 0;
         for (int r = 0; r < NREG; r++) m_pend[r] = 1'b0;
         for (int i = 0; i < NRD; i++) begin
            m_hd[i] = '0;
            m_hb[i] = 1'b0;
         end
      end else begin
         run = (m_cnt >= NREG);
         if (run) begin
            // Writes in port order: the later port overwrites the earlier one.
            for (int j = 0; j < NWR; j++) begin
               a = int'(wr_addr[j*AW +: AW]);
               if (wr_en[j] && a != 0 && a < NREG) begin
                  m_regs[a] = wr_data[j*XLEN +: XLEN];
                  m_pend[a] = 1'b0;
               end
            end
            a = int'(rsv_addr);
            if (rsv_en && a != 0 && a < NREG) m_pend[a] = 1'b1;
         end
         // Reads see the updated model, which is exactly the bypass result.
         for (int i = 0; i < NRD; i++) begin
            if (rd_en[i]) begin
               a = int'(rd_addr[i*AW +: AW]);
               if (run && a != 0 && a < NREG) begin
                  m_hd[i] = m_regs[a];
                  m_hb[i] = m_pend[a];
               end else begin
                  m_hd[i] = '0;
                  m_hb[i] = 1'b0;
               end
            end
         end
         if (!run) begin
            m_cnt++;
            if (m_cnt == NREG) begin
               for (int r = 0; r < NREG; r++) m_regs[r] = '0;
            end
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NRD; i++) begin
         check($sformatf("rd_data[%0d]", i), 64'(rd_data[i*XLEN +: XLEN]), 64'(m_hd[i]));
         check($sformatf("rd_busy[%0d]", i), 64'(rd_busy[i]), 64'(m_hb[i]));
      end
      check("init_done", 64'(init_done), 64'(m_cnt >= NREG));
   endtask

   // Count cycles from reset release until init_done, bounded.
   task automatic wait_init(input string tag);
      int n;
      n = 0;
      while (init_done !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      check(tag, 64'(n), 64'(NREG));
   endtask

   initial begin
      for (int r = 0; r < NREG; r++) m_regs[r] = '0;
      idle();

      // ---------------- reset and start-up sweep ----------------
      rst = 1'b1;
      step();
      step();
      check("rst_rd_data", 64'(rd_data), 64'(0));
      check("rst_rd_busy", 64'(rd_busy), 64'(0));
      check("rst_init_done", 64'(init_done), 64'(0));
      rst = 1'b0;
      wait_init("init_cycles");

      // Every address reads zero after the sweep.
      for (int r = 0; r < NREG; r += 2) begin
         idle();
         set_rd(0, 1'b1, r);
         set_rd(1, 1'b1, r + 1);
         step();
         check($sformatf("zero_r%0d", r), 64'(rd_data), 64'(0));
      end

      // ---------------- bypass and r0 ----------------
      idle();
      set_wr(0, 1'b1, 5, 32'hDEAD_BEEF);
      set_rd(0, 1'b1, 5);
      step();
      check("r5_bypass", 64'(rd_data[0 +: XLEN]), 64'h0000_0000_DEAD_BEEF);

      idle();
      set_wr(0, 1'b1, 0, 32'h1234);
      set_rd(1, 1'b1, 0);
      step();
      check("r0_same_cycle", 64'(rd_data[XLEN +: XLEN]), 64'(0));
      idle();
      set_rd(0, 1'b1, 0);
      step();
      check("r0_later", 64'(rd_data[0 +: XLEN]), 64'(0));

      // ---------------- multi-port write priority ----------------
      idle();
      set_wr(0, 1'b1, 7, 32'h11);
      set_wr(1, 1'b1, 7, 32'h22);
      set_rd(0, 1'b1, 7);
      step();
      check("r7_bypass_prio", 64'(rd_data[0 +: XLEN]), 64'h22);
      idle();
      set_rd(1, 1'b1, 7);
      step();
      check("r7_stored_prio", 64'(rd_data[XLEN +: XLEN]), 64'h22);

      // ---------------- scoreboard ----------------
      idle();
      set_rsv(1'b1, 3);
      set_rd(0, 1'b1, 3);
      step();
      check("r3_reserved_busy", 64'(rd_busy[0]), 64'(1));
      idle();
      set_wr(1, 1'b1, 3, 32'h5);
      set_rd(0, 1'b1, 3);
      step();
      check("r3_written_busy", 64'(rd_busy[0]), 64'(0));
      check("r3_written_data", 64'(rd_data[0 +: XLEN]), 64'h5);
      idle();
      set_rsv(1'b1, 3);
      set_wr(0, 1'b1, 3, 32'h6);
      set_rd(1, 1'b1, 3);
      step();
      check("r3_rsv_and_wr_busy", 64'(rd_busy[1]), 64'(1));

      // ---------------- hold while disabled ----------------
      idle();
      set_wr(0, 1'b1, 9, 32'hA);
      step();
      idle();
      set_rd(0, 1'b1, 9);
      step();
      check("r9_read_a", 64'(rd_data[0 +: XLEN]), 64'hA);
      idle();
      set_wr(1, 1'b1, 9, 32'hB);
      step();
      check("r9_hold_1", 64'(rd_data[0 +: XLEN]), 64'hA);
      idle();
      step();
      check("r9_hold_2", 64'(rd_data[0 +: XLEN]), 64'hA);
      set_rd(0, 1'b1, 9);
      step();
      check("r9_read_b", 64'(rd_data[0 +: XLEN]), 64'hB);

      // ---------------- reset in the middle of the sweep ----------------
      idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         set_rd(0, 1'b1, k + 1);
         step();
      end
      check("mid_init_done", 64'(init_done), 64'(0));
      idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
      wait_init("reinit_cycles");

      // ---------------- randomized traffic ----------------
      for (int n = 0; n < 3000; n++) begin
         idle();
         rst = ($urandom_range(0, 599) == 0);
         for (int i = 0; i < NRD; i++) begin
            set_rd(i, ($urandom_range(0, 3) != 0), $urandom_range(0, 15));
         end
         for (int j = 0; j < NWR; j++) begin
            set_wr(j, $urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom);
         end
         set_rsv($urandom_range(0, 9) < 3, $urandom_range(0, 15));
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/core_id_reg_file_mp.md
CORE_ID_REG_FILE_MP -- requirements
Module: core_id_reg_file_mp

Interface
REQ-001 Parameter XLEN, default 32: register data width in bits.
REQ-002 Parameter NREG, default 32: number of architectural registers; AW = clog2(NREG).
REQ-003 Parameter NRD, default 2: number of read ports.
REQ-004 Parameter NWR, default 2: number of write ports.
REQ-005 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1: reset; synchronous and active-high.
REQ-007 Port rd_en, input, NRD: per-port read enable.
REQ-008 Port rd_addr, input, NRD*AW: packed read addresses; port i occupies bits [i*AW +: AW].
REQ-009 Port rd_data, output, NRD*XLEN: packed registered read data.
REQ-010 Port rd_busy, output, NRD: registered pending flag for each port's captured address.
REQ-011 Port wr_en, input, NWR: per-port write enable.
REQ-012 Port wr_addr, input, NWR*AW: packed write addresses.
REQ-013 Port wr_data, input, NWR*XLEN: packed write data.
REQ-014 Port rsv_en, input, 1: reserve the destination register of an issued instruction.
REQ-015 Port rsv_addr, input, AW: register to mark pending.
REQ-016 Port init_done, output, 1: high once register clearing is complete.

Function
REQ-017 The read latency SHALL be one cycle: when rd_en[i] is high at an edge, rd_data[i] and rd_busy[i] update at that edge.
REQ-018 When rd_en[i] is low, rd_data[i] and rd_busy[i] SHALL hold their last values; later writes do not alter held data.
REQ-019 A read of address 0 SHALL return 0 and rd_busy 0; writes and reservations to address 0 SHALL be ignored.
REQ-020 Same-cycle write and read of the same nonzero address SHALL be bypassed: rd_data returns the new write data.
REQ-021 When several write ports target one address in a cycle, the highest-index enabled port SHALL win, for both storage and bypass.
REQ-022 Addresses >= NREG SHALL read as 0 and SHALL be ignored for writes and reservations.
REQ-023 Scoreboard: rsv_en SHALL set pending[rsv_addr]; any enabled write SHALL clear pending[wr_addr]; both take effect at the same edge.
REQ-024 A simultaneous reservation and write to the same address SHALL leave pending set.
REQ-025 rd_busy[i] SHALL be captured from the post-edge pending value, so a same-cycle write clears it and a same-cycle reservation sets it.
REQ-026 State machine INIT -> RUN; INIT writes 0 to register idx, idx increments 0..NREG-1 one per cycle, and the transition to RUN happens after idx NREG-1 is written.
REQ-027 In INIT: external writes and reservations SHALL be ignored, reads SHALL return 0 with busy 0, and init_done = 0.
REQ-028 In RUN: init_done = 1; the state remains RUN until rst.

Reset
REQ-029 When rst is high at an edge, the following SHALL apply:
- state = INIT, idx = 0.
- rd_data = 0, rd_busy = 0.
- all pending bits = 0.
- init_done = 0.
REQ-030 Asserting rst mid-INIT or in RUN SHALL restart clearing from idx 0; register contents are not cleared by rst itself, only by the INIT sweep.

Structure
REQ-031 Shared package core_pkg SHALL hold:
- the state enum rf_state_t {RF_INIT, RF_RUN};
- default XLEN and NREG constants.
REQ-032 The scoreboard (pending bits, set/clear priority, lookup) SHALL be the sub-module core_id_reg_file_sb; storage, bypass and the init FSM stay in the top.

Verification
REQ-033 Reset, then count cycles until init_done -> rises exactly NREG (32) cycles after rst deasserts; every address then reads 0.
REQ-034 In RUN, write 0xDEADBEEF to r5 and read r5 in the same cycle -> rd_data = 0xDEADBEEF next cycle; write r0 = 0x1234 -> r0 reads 0.
REQ-035 Port 0 writes r7 = 0x11 and port 1 writes r7 = 0x22 in the same cycle -> r7 reads 0x22, including on a same-cycle bypass read.
REQ-036 Reserve r3 -> read r3 gives busy = 1; write r3 = 0x5 -> busy = 0, data 0x5; reserve and write r3 together -> busy = 1.
REQ-037 Read r9 = 0xA, deassert rd_en, then write r9 = 0xB -> rd_data stays 0xA until the next enabled read.
REQ-038 Assert rst at idx 10 during INIT -> idx restarts at 0, and init_done rises 32 cycles after release.
